// File: rtl/pitch_lookup_arbiter_pkg.sv
// Shared sequencer types and constants for the pitch lookup arbiter.
package pitch_lookup_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StWait    = 2'd2,
    StRespond = 2'd3
  } arb_state_e;

  // Wide enough for the largest supported timeout (255 cycles).
  localparam int unsigned TmoCntWidth = 8;
  typedef logic [TmoCntWidth-1:0] tmo_cnt_t;

  // Count value in the last WAIT cycle before giving up; a response in that
  // cycle still completes normally.
  function automatic tmo_cnt_t tmo_last_count(input int unsigned timeout_cycles);
    return tmo_cnt_t'(timeout_cycles - 2);
  endfunction

endpackage

// File: rtl/pitch_lookup_arbiter_if.sv
// Channel request/ack bus plus the shared pitch lookup port, grouped for the arbiter.
interface pitch_lookup_arbiter_if #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned NOTE_WIDTH   = 6,
  parameter int unsigned PITCH_WIDTH  = 16
);

  logic [NUM_CHANNELS-1:0]            i_req;
  logic [NUM_CHANNELS*NOTE_WIDTH-1:0] i_note;
  logic                               o_lookup_enable;
  logic [NOTE_WIDTH-1:0]              o_lookup_note;
  logic                               i_lookup_valid;
  logic [PITCH_WIDTH-1:0]             i_lookup_pitch;
  logic [NUM_CHANNELS-1:0]            o_ack;
  logic [PITCH_WIDTH-1:0]             o_pitch;
  logic                               o_error;
  logic                               o_busy;

  modport slave (
    input  i_req, i_note, i_lookup_valid, i_lookup_pitch,
    output o_lookup_enable, o_lookup_note, o_ack, o_pitch, o_error, o_busy
  );

  modport master (
    output i_req, i_note, i_lookup_valid, i_lookup_pitch,
    input  o_lookup_enable, o_lookup_note, o_ack, o_pitch, o_error, o_busy
  );

endinterface

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first request at or after the pointer, wrapping.
module rr_priority_select #(
  parameter int unsigned  NUM_CHANNELS = 4,
  localparam int unsigned IdxWidth     = $clog2(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] i_req,
  input  logic [IdxWidth-1:0]     i_ptr,
  output logic [NUM_CHANNELS-1:0] o_grant,
  output logic [IdxWidth-1:0]     o_idx,
  output logic                    o_valid
);

  logic [IdxWidth-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      w_cand = IdxWidth'((i_ptr + i) % NUM_CHANNELS);
      if (!o_valid && i_req[w_cand]) begin
        o_valid         = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pitch_lookup_arbiter.sv
// Round-robin arbiter sharing one pitch lookup among channel controllers,
// with a bounded wait for the lookup response.
module pitch_lookup_arbiter
  import pitch_lookup_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS   = 4,
  parameter int unsigned NOTE_WIDTH     = 6,
  parameter int unsigned PITCH_WIDTH    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input logic                   i_clk,
  input logic                   i_rst,
  pitch_lookup_arbiter_if.slave bus
);

  localparam int unsigned IdxWidth = $clog2(NUM_CHANNELS);
  localparam tmo_cnt_t    TmoLast  = tmo_last_count(TIMEOUT_CYCLES);

  arb_state_e              r_state, w_state_next;
  logic [NUM_CHANNELS-1:0] r_gnt_oh;
  logic [IdxWidth-1:0]     r_gnt_idx;
  logic [IdxWidth-1:0]     r_rr_ptr;
  logic [NOTE_WIDTH-1:0]   r_note;
  logic [PITCH_WIDTH-1:0]  r_pitch;
  logic                    r_err;
  tmo_cnt_t                r_tmo_cnt;

  logic [NUM_CHANNELS-1:0] w_grant_oh;
  logic [IdxWidth-1:0]     w_grant_idx;
  logic                    w_grant_valid;
  logic [NOTE_WIDTH-1:0]   w_notes [NUM_CHANNELS];
  logic [NOTE_WIDTH-1:0]   w_sel_note;
  logic                    w_tmo_hit;

  rr_priority_select #(
    .NUM_CHANNELS(NUM_CHANNELS)
  ) u_rr_sel (
    .i_req   (bus.i_req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant_oh),
    .o_idx   (w_grant_idx),
    .o_valid (w_grant_valid)
  );

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_note
    assign w_notes[g] = bus.i_note[g*NOTE_WIDTH +: NOTE_WIDTH];
  end

  assign w_sel_note = w_notes[w_grant_idx];
  assign w_tmo_hit  = (r_tmo_cnt == TmoLast);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:    if (w_grant_valid) w_state_next = StIssue;
      StIssue:   w_state_next = StWait;
      StWait:    if (bus.i_lookup_valid || w_tmo_hit) w_state_next = StRespond;
      StRespond: w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_gnt_oh  <= '0;
      r_gnt_idx <= '0;
      r_rr_ptr  <= '0;
      r_note    <= '0;
      r_pitch   <= '0;
      r_err     <= 1'b0;
      r_tmo_cnt <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_grant_valid) begin
            r_gnt_oh  <= w_grant_oh;
            r_gnt_idx <= w_grant_idx;
            r_note    <= w_sel_note;
          end
        end
        StIssue: r_tmo_cnt <= '0;
        StWait: begin
          // A response in the final wait cycle wins over the timeout.
          if (bus.i_lookup_valid) begin
            r_pitch <= bus.i_lookup_pitch;
            r_err   <= 1'b0;
          end else if (w_tmo_hit) begin
            r_pitch <= '0;
            r_err   <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        StRespond: begin
          r_rr_ptr <= (r_gnt_idx == IdxWidth'(NUM_CHANNELS - 1)) ? '0 : r_gnt_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.o_lookup_enable = (r_state == StIssue);
    bus.o_busy          = (r_state != StIdle);
    bus.o_ack           = '0;
    bus.o_error         = 1'b0;
    if (r_state == StRespond) begin
      bus.o_ack   = r_gnt_oh;
      bus.o_error = r_err;
    end
  end

  assign bus.o_lookup_note = r_note;
  assign bus.o_pitch       = r_pitch;

endmodule

// File: tb/tb_pitch_lookup_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// round-robin/timeout reference model.
module tb_pitch_lookup_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned NW  = 6;
  localparam int unsigned PW  = 16;
  localparam int unsigned TMO = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [NW-1:0] notes [N];

  pitch_lookup_arbiter_if #(.NUM_CHANNELS(N), .NOTE_WIDTH(NW), .PITCH_WIDTH(PW)) bus ();

  pitch_lookup_arbiter #(
    .NUM_CHANNELS   (N),
    .NOTE_WIDTH     (NW),
    .PITCH_WIDTH    (PW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_notes();
    for (int k = 0; k < N; k++) bus.i_note[k*NW +: NW] = notes[k];
  endtask

  task automatic wait_enable(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (bus.o_lookup_enable === 1'b1) seen = 1'b1;
    end
  endtask

  // Reference rule: first requester at or after ptr, ascending and wrapping.
  function automatic int rr_pick(input logic [N-1:0] vec, input int ptr);
    for (int i = 0; i < N; i++) if (vec[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.i_req = '0;
    bus.i_lookup_valid = 1'b0;
    bus.i_lookup_pitch = '0;
    for (int k = 0; k < N; k++) notes[k] = NW'(k + 1);
    drive_notes();
    repeat (3) tick();
    checks++;
    if (bus.o_ack !== '0 || bus.o_lookup_enable !== 1'b0 || bus.o_error !== 1'b0)
      begin errors++; $display("FAIL reset_strobes: ack=%b en=%b err=%b expected all 0",
                               bus.o_ack, bus.o_lookup_enable, bus.o_error); end
    checks++;
    if (bus.o_pitch !== '0 || bus.o_lookup_note !== '0 || bus.o_busy !== 1'b0)
      begin errors++; $display("FAIL reset_data: pitch=%h note=%h busy=%b expected 0",
                               bus.o_pitch, bus.o_lookup_note, bus.o_busy); end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_lookup_enable !== 1'b0)
      begin errors++; $display("FAIL reset_idle: busy=%b en=%b expected 0 with no requests",
                               bus.o_busy, bus.o_lookup_enable); end
  endtask

  task automatic test_single();
    notes[0] = 6'd12;
    drive_notes();
    bus.i_req = 4'b0001;
    tick();
    checks++;
    if (bus.o_lookup_enable !== 1'b1 || bus.o_lookup_note !== 6'd12 || bus.o_busy !== 1'b1)
      begin errors++; $display("FAIL single_issue: en=%b note=%0d busy=%b expected 1/12/1",
                               bus.o_lookup_enable, bus.o_lookup_note, bus.o_busy); end
    tick();
    checks++;
    if (bus.o_lookup_enable !== 1'b0)
      begin errors++; $display("FAIL single_enable_width: en=%b expected 0", bus.o_lookup_enable); end
    bus.i_lookup_valid = 1'b1;
    bus.i_lookup_pitch = 16'h1A2B;
    tick();
    bus.i_lookup_valid = 1'b0;
    checks++;
    if (bus.o_ack !== 4'b0001 || bus.o_pitch !== 16'h1A2B || bus.o_error !== 1'b0)
      begin errors++; $display("FAIL single_ack: ack=%b pitch=%h err=%b expected 0001/1a2b/0",
                               bus.o_ack, bus.o_pitch, bus.o_error); end
    bus.i_req = '0;
    tick();
    checks++;
    if (bus.o_ack !== '0 || bus.o_pitch !== 16'h1A2B || bus.o_busy !== 1'b0)
      begin errors++; $display("FAIL single_after: ack=%b pitch=%h busy=%b expected 0000/1a2b/0",
                               bus.o_ack, bus.o_pitch, bus.o_busy); end
  endtask

  task automatic test_stray_valid();
    bus.i_lookup_valid = 1'b1;
    bus.i_lookup_pitch = 16'hDEAD;
    tick();
    tick();
    checks++;
    if (bus.o_ack !== '0 || bus.o_busy !== 1'b0 || bus.o_pitch !== 16'h1A2B)
      begin errors++; $display("FAIL stray_idle: ack=%b busy=%b pitch=%h expected 0000/0/1a2b",
                               bus.o_ack, bus.o_busy, bus.o_pitch); end
    notes[1] = 6'h21;
    drive_notes();
    bus.i_req = 4'b0010;
    bus.i_lookup_pitch = 16'hBEEF;
    tick();
    checks++;
    if (bus.o_lookup_enable !== 1'b1 || bus.o_lookup_note !== 6'h21)
      begin errors++; $display("FAIL stray_grant: en=%b note=%h expected 1/21",
                               bus.o_lookup_enable, bus.o_lookup_note); end
    tick();
    checks++;
    if (bus.o_ack !== '0 || bus.o_pitch !== 16'h1A2B)
      begin errors++; $display("FAIL stray_issue: ack=%b pitch=%h expected 0000/1a2b",
                               bus.o_ack, bus.o_pitch); end
    bus.i_lookup_pitch = 16'h4C4C;
    tick();
    bus.i_lookup_valid = 1'b0;
    checks++;
    if (bus.o_ack !== 4'b0010 || bus.o_pitch !== 16'h4C4C || bus.o_error !== 1'b0)
      begin errors++; $display("FAIL stray_followup: ack=%b pitch=%h err=%b expected 0010/4c4c/0",
                               bus.o_ack, bus.o_pitch, bus.o_error); end
    bus.i_req = '0;
    tick();
  endtask

  task automatic test_timeout();
    bit seen;
    int n;
    notes[2] = 6'h33;
    drive_notes();
    bus.i_req = 4'b0100;
    wait_enable(6, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL timeout_enable: got no enable, expected one"); end
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.o_ack === '0 && n < 20);
    checks++;
    if (n != TMO) begin errors++; $display("FAIL timeout_latency: got %0d cycles expected %0d", n, TMO); end
    checks++;
    if (bus.o_ack !== 4'b0100 || bus.o_error !== 1'b1 || bus.o_pitch !== '0)
      begin errors++; $display("FAIL timeout_ack: ack=%b err=%b pitch=%h expected 0100/1/0000",
                               bus.o_ack, bus.o_error, bus.o_pitch); end
    bus.i_req = '0;
    tick();
    checks++;
    if (bus.o_error !== 1'b0 || bus.o_ack !== '0)
      begin errors++; $display("FAIL timeout_pulse: err=%b ack=%b expected 0/0000",
                               bus.o_error, bus.o_ack); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    bit bad;
    notes[0] = 6'h05;
    notes[3] = 6'h2A;
    drive_notes();
    bus.i_req = 4'b0100;
    wait_enable(6, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL rstmid_enable: got no enable, expected one"); end
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.i_req = '0;
    bus.i_lookup_valid = 1'b1;
    bus.i_lookup_pitch = 16'h7777;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ({bus.o_ack, bus.o_lookup_enable, bus.o_lookup_note, bus.o_pitch, bus.o_error,
           bus.o_busy} !== '0) bad = 1'b1;
      tick();
      bus.i_lookup_valid = 1'b0;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL rstmid_quiet: outputs=%h expected all 0 after reset",
      {bus.o_ack, bus.o_lookup_enable, bus.o_lookup_note, bus.o_pitch, bus.o_error, bus.o_busy}); end
    bus.i_req = 4'b1001;
    wait_enable(6, seen);
    checks++;
    if (!seen || bus.o_lookup_note !== notes[0])
      begin errors++; $display("FAIL rstmid_ptr: seen=%b note=%h expected 1/%h (channel 0)",
                               seen, bus.o_lookup_note, notes[0]); end
    tick();
    bus.i_lookup_valid = 1'b1;
    bus.i_lookup_pitch = 16'h3C3C;
    tick();
    bus.i_lookup_valid = 1'b0;
    checks++;
    if (bus.o_ack !== 4'b0001 || bus.o_pitch !== 16'h3C3C)
      begin errors++; $display("FAIL rstmid_ack: ack=%b pitch=%h expected 0001/3c3c",
                               bus.o_ack, bus.o_pitch); end
    bus.i_req = '0;
    tick();
  endtask

  task automatic test_round_robin();
    bit seen;
    int lat;
    logic [N-1:0] exp_ack;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.i_req = '1;
    for (int t = 0; t < 5; t++) begin
      wait_enable(6, seen);
      checks++;
      if (!seen) begin errors++; $display("FAIL rr_enable: txn %0d got no enable", t); break; end
      lat = $urandom_range(1, 3);
      for (int j = 1; j <= lat + 1; j++) begin
        tick();
        bus.i_lookup_valid = (j == lat);
        bus.i_lookup_pitch = PW'(t * 16'h1111);
      end
      exp_ack = '0;
      exp_ack[t % N] = 1'b1;
      checks++;
      if (bus.o_ack !== exp_ack)
        begin errors++; $display("FAIL rr_order: txn %0d ack=%b expected %b", t, bus.o_ack, exp_ack); end
      checks++;
      if (bus.o_pitch !== PW'(t * 16'h1111))
        begin errors++; $display("FAIL rr_pitch: txn %0d pitch=%h expected %h",
                                 t, bus.o_pitch, PW'(t * 16'h1111)); end
    end
    bus.i_req = '0;
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] pending;
    logic [N-1:0] exp_ack;
    logic [PW-1:0] pv;
    logic [PW-1:0] exp_pitch;
    bit seen, early, exp_err, unfair;
    int ptr, ch, lat, off;
    int waits [N];
    for (int k = 0; k < N; k++) begin
      notes[k] = NW'($urandom);
      waits[k] = 0;
    end
    drive_notes();
    ptr = 1;  // last grant of the round-robin test was channel 0
    pending = '0;
    for (int t = 0; t < 40; t++) begin
      if (pending == '0) pending[$urandom_range(0, N - 1)] = 1'b1;
      bus.i_req = pending;
      ch = rr_pick(pending, ptr);
      wait_enable(6, seen);
      checks++;
      if (!seen) begin errors++; $display("FAIL rand_enable: txn %0d got no enable", t); break; end
      checks++;
      if (bus.o_lookup_note !== notes[ch])
        begin errors++; $display("FAIL rand_note: txn %0d note=%h expected %h (ch %0d)",
                                 t, bus.o_lookup_note, notes[ch], ch); end
      if ($urandom_range(0, 3) == 0) bus.i_req[ch] = 1'b0;
      lat = $urandom_range(1, TMO + 1);
      exp_err = (lat > TMO - 1);
      off = exp_err ? TMO : lat + 1;
      pv = PW'($urandom);
      exp_pitch = exp_err ? '0 : pv;
      early = 1'b0;
      for (int j = 1; j <= off; j++) begin
        tick();
        if (j < off && bus.o_ack !== '0) early = 1'b1;
        bus.i_lookup_valid = (j == lat) && !exp_err;
        bus.i_lookup_pitch = (j == lat) ? pv : PW'($urandom);
      end
      exp_ack = '0;
      exp_ack[ch] = 1'b1;
      checks++;
      if (early || bus.o_ack !== exp_ack)
        begin errors++; $display("FAIL rand_ack: txn %0d ack=%b early=%b expected %b at +%0d",
                                 t, bus.o_ack, early, exp_ack, off); end
      checks++;
      if (bus.o_pitch !== exp_pitch || bus.o_error !== exp_err)
        begin errors++; $display("FAIL rand_result: txn %0d pitch=%h err=%b expected %h/%b",
                                 t, bus.o_pitch, bus.o_error, exp_pitch, exp_err); end
      unfair = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (pending[k] && bus.o_ack[k] !== 1'b1) waits[k]++;
        else waits[k] = 0;
        if (waits[k] > N - 1) unfair = 1'b1;
      end
      checks++;
      if (unfair) begin errors++; $display("FAIL rand_fair: txn %0d a channel waited over %0d grants",
                                           t, N - 1); end
      pending[ch] = 1'b0;
      pending = pending | (N'($urandom) & N'($urandom) & ~exp_ack);
      bus.i_req = pending;
      ptr = (ch + 1) % N;
    end
    bus.i_req = '0;
    bus.i_lookup_valid = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_stray_valid();
    test_timeout();
    test_reset_mid();
    test_round_robin();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pitch_lookup_arbiter.md
PITCH_LOOKUP_ARBITER -- requirements
Module: pitch_lookup_arbiter

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, number of requesting channel controllers (2..8).
REQ-002 SHALL have parameter NOTE_WIDTH, default 6, note index width.
REQ-003 SHALL have parameter PITCH_WIDTH, default 16, phase-increment width returned by the lookup.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 8, maximum wait for lookup response (2..255).
REQ-005 SHALL have port i_clk, input, 1, sole clock.
REQ-006 SHALL have port i_rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port i_req, input, NUM_CHANNELS, per-channel lookup request, level, held until acked.
REQ-008 SHALL have port i_note, input, NUM_CHANNELS*NOTE_WIDTH, per-channel note, channel k at bits [k*NOTE_WIDTH +: NOTE_WIDTH], stable while i_req[k] high.
REQ-009 SHALL have port o_lookup_enable, output, 1, one-cycle strobe to the shared pitch lookup.
REQ-010 SHALL have port o_lookup_note, output, NOTE_WIDTH, note presented to the lookup.
REQ-011 SHALL have port i_lookup_valid, input, 1, lookup response strobe.
REQ-012 SHALL have port i_lookup_pitch, input, PITCH_WIDTH, lookup result, valid with i_lookup_valid.
REQ-013 SHALL have port o_ack, output, NUM_CHANNELS, one-hot one-cycle completion pulse.
REQ-014 SHALL have port o_pitch, output, PITCH_WIDTH, result broadcast to all channels, valid with o_ack.
REQ-015 SHALL have port o_error, output, 1, asserted with o_ack when the transaction timed out.
REQ-016 SHALL have port o_busy, output, 1, high whenever state is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, RESPOND.
REQ-018 IDLE: if any i_req bit high, SHALL grant the first requester at or after rr_ptr (ascending, wrapping), latch grant index and its note, go to ISSUE; else stay.
REQ-019 ISSUE: SHALL assert o_lookup_enable for exactly one cycle with o_lookup_note = latched note, clear timeout counter, go to WAIT.
REQ-020 WAIT: on i_lookup_valid SHALL register i_lookup_pitch into o_pitch, clear error flag, go to RESPOND.
REQ-021 WAIT: SHALL count cycles; when count reaches TIMEOUT_CYCLES-1 without i_lookup_valid, SHALL set o_pitch = 0, set error flag, go to RESPOND.
REQ-022 RESPOND: SHALL assert o_ack[grant] and o_error (if flagged) for exactly one cycle, set rr_ptr = (grant+1) mod NUM_CHANNELS, go to IDLE.
REQ-023 o_lookup_note SHALL hold the latched note in all states other than IDLE; o_pitch SHALL hold its value until the next capture.
REQ-024 Latency: request seen in IDLE at cycle T -> o_lookup_enable at T+1; lookup valid at T+1+L -> o_ack at T+2+L.
REQ-025 i_lookup_valid outside WAIT SHALL be ignored.
REQ-026 i_req changes during a transaction SHALL not alter the grant; a withdrawn request still receives its ack.
REQ-027 i_lookup_valid arriving in the timeout cycle SHALL take priority (normal completion, no error).
REQ-028 Requester SHALL drop i_req at the clock edge where o_ack is sampled; arbiter SHALL re-arbitrate in the IDLE cycle after RESPOND.
REQ-029 No channel SHALL wait more than NUM_CHANNELS-1 transactions once requesting.

Reset
REQ-030 On i_rst: state IDLE, rr_ptr 0, o_ack 0, o_lookup_enable 0, o_lookup_note 0, o_pitch 0, o_error 0, o_busy 0, timeout counter 0.
REQ-031 Reset mid-transaction SHALL abandon it with no ack; a later i_lookup_valid SHALL be ignored.

Structure
REQ-032 State encodings and timeout counter width SHALL live in a shared package with the other sequencer constants.
REQ-033 Round-robin selection SHALL be a sub-module rr_priority_select (request vector + pointer in, one-hot grant + index out, combinational).

Verification
REQ-034 Single req: i_req=0001, note 12, lookup latency 1 returns 0x1A2B -> o_lookup_enable T+1 with note 12, o_ack=0001 at T+3, o_pitch=0x1A2B, o_error=0.
REQ-035 All four request continuously from reset -> grant order 0,1,2,3,0; each ack one-hot, no repeats before wrap.
REQ-036 Timeout: i_req=0100, no i_lookup_valid -> o_ack=0100 with o_error=1, o_pitch=0, 8 cycles after o_lookup_enable.
REQ-037 Stray i_lookup_valid in IDLE and ISSUE -> no ack, o_pitch unchanged.
REQ-038 i_rst pulsed during WAIT, then valid arrives -> no ack, all outputs 0, next request granted from channel 0.
